// File: rtl/core_seq.sv
// Tile sequencer: walks weight load, activation read, execute and OFIFO drain,
// emitting one registered 36-bit core instruction word per cycle.
module core_seq #(
    parameter int unsigned row        = 8,
    parameter int unsigned col        = 8,
    parameter int unsigned addr_width = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [addr_width-1:0] w_base,
    input  logic [addr_width-1:0] x_base,
    input  logic [addr_width-1:0] p_base,
    input  logic [7:0]            n_act,
    input  logic                  ofifo_valid,
    output logic [35:0]           inst,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LOG_W  = $clog2(row + col) + 1;
    localparam int unsigned CNT_W  = (LOG_W > 8) ? LOG_W : 8;
    localparam int unsigned INST_W = 36;

    localparam int unsigned B_LOAD = 0;
    localparam int unsigned B_EXEC = 1;
    localparam int unsigned B_L0WR = 2;
    localparam int unsigned B_L0RD = 3;
    localparam int unsigned B_ORD  = 4;
    localparam int unsigned B_AX   = 8;
    localparam int unsigned B_WENX = 19;
    localparam int unsigned B_CENX = 20;
    localparam int unsigned B_AP   = 21;
    localparam int unsigned B_WENP = 32;
    localparam int unsigned B_CENP = 33;

    // Both SRAMs deselected and write-disabled, everything else zero.
    localparam logic [INST_W-1:0] IDLE_WORD = 36'h3_0018_0000;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] W_RD   = 3'd1;
    localparam logic [2:0] W_LOAD = 3'd2;
    localparam logic [2:0] X_RD   = 3'd3;
    localparam logic [2:0] EXEC   = 3'd4;
    localparam logic [2:0] DRAIN  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    logic [2:0]            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [CNT_W-1:0]      wr_cnt, wr_cnt_d;
    logic [addr_width-1:0] w_base_q, w_base_d;
    logic [addr_width-1:0] x_base_q, x_base_d;
    logic [addr_width-1:0] p_base_q, p_base_d;
    logic [7:0]            n_act_q, n_act_d;
    logic [INST_W-1:0]     inst_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  rd_fire;
    logic [CNT_W-1:0]      n_ext;

    assign n_ext = CNT_W'(n_act_q);

    // Next state, counters and the instruction word for the cycle being entered.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        wr_cnt_d = wr_cnt;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        p_base_d = p_base_q;
        n_act_d  = n_act_q;
        rd_fire  = 1'b0;
        inst_d   = IDLE_WORD;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state)
            IDLE: begin
                if (start && (n_act != 8'd0)) begin
                    state_d  = W_RD;
                    cnt_d    = '0;
                    w_base_d = w_base;
                    x_base_d = x_base;
                    p_base_d = p_base;
                    n_act_d  = n_act;
                end
            end
            W_RD: begin
                if (cnt == CNT_W'(row - 1)) begin
                    state_d = W_LOAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            W_LOAD: begin
                if (cnt == CNT_W'(row + col - 1)) begin
                    state_d = X_RD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            X_RD: begin
                if (cnt == n_ext - CNT_W'(1)) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            EXEC: begin
                if (cnt == n_ext - CNT_W'(1)) begin
                    state_d  = DRAIN;
                    cnt_d    = '0;
                    wr_cnt_d = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                // cnt counts pops, wr_cnt counts pmem writes already launched.
                rd_fire = ofifo_valid && (cnt < n_ext);
                if (rd_fire) begin
                    cnt_d = cnt + CNT_W'(1);
                end
                if (inst[B_ORD]) begin
                    wr_cnt_d = wr_cnt + CNT_W'(1);
                end
                if (!inst[B_CENP] && (wr_cnt == n_ext)) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    wr_cnt_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            W_RD: begin
                inst_d[B_CENX]               = 1'b0;
                inst_d[B_AX +: addr_width]   = w_base_d + addr_width'(cnt_d);
            end
            W_LOAD: begin
                inst_d[B_LOAD]               = 1'b1;
                inst_d[B_L0RD]               = (cnt_d < CNT_W'(row));
            end
            X_RD: begin
                inst_d[B_CENX]               = 1'b0;
                inst_d[B_AX +: addr_width]   = x_base_d + addr_width'(cnt_d);
            end
            EXEC: begin
                inst_d[B_EXEC]               = 1'b1;
                inst_d[B_L0RD]               = 1'b1;
            end
            DRAIN: begin
                inst_d[B_ORD]                = rd_fire;
                if (inst[B_ORD]) begin
                    inst_d[B_CENP]             = 1'b0;
                    inst_d[B_WENP]             = 1'b0;
                    inst_d[B_AP +: addr_width] = p_base_q + addr_width'(wr_cnt);
                end
            end
            default: begin
                inst_d = IDLE_WORD;
            end
        endcase

        // L0 write trails the xmem read strobe by the SRAM read latency.
        inst_d[B_L0WR] = ~inst[B_CENX];
        busy_d         = (state_d != IDLE);
        done_d         = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_cnt   <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            p_base_q <= '0;
            n_act_q  <= '0;
            inst     <= IDLE_WORD;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            wr_cnt   <= wr_cnt_d;
            w_base_q <= w_base_d;
            x_base_q <= x_base_d;
            p_base_q <= p_base_d;
            n_act_q  <= n_act_d;
            inst     <= inst_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: table-driven tiles, randomized tiles and
// hand-written reset / ignored-start sequences against a phase-list model.
module tb_core_seq;

    localparam int ROW = 8;
    localparam int COL = 8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] w_base, x_base, p_base;
    logic [7:0]  n_act;
    logic        ofifo_valid;
    logic [35:0] inst;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    core_seq #(.row(ROW), .col(COL), .addr_width(11)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .w_base     (w_base),
        .x_base     (x_base),
        .p_base     (p_base),
        .n_act      (n_act),
        .ofifo_valid(ofifo_valid),
        .inst       (inst),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          load;
        bit          ex;
        bit          l0rd;
        bit          xrd;
        logic [10:0] ax;
    } pre_t;

    typedef struct {
        logic [10:0] wb;
        logic [10:0] xb;
        logic [10:0] pb;
        logic [7:0]  n;
        int          mode;
        bit          poke;
        int          exp_busy;
    } vec_t;

    function automatic logic [35:0] word(input bit load, input bit ex, input bit l0wr,
                                         input bit l0rd, input bit ordd, input bit xrd,
                                         input logic [10:0] ax, input bit pwr,
                                         input logic [10:0] ap);
        logic [35:0] w;
        w        = '0;
        w[0]     = load;
        w[1]     = ex;
        w[2]     = l0wr;
        w[3]     = l0rd;
        w[4]     = ordd;
        w[18:8]  = xrd ? ax : 11'h0;
        w[19]    = 1'b1;
        w[20]    = ~xrd;
        w[31:21] = pwr ? ap : 11'h0;
        w[32]    = ~pwr;
        w[33]    = ~pwr;
        return w;
    endfunction

    task automatic check(input string name, input int cyc, input logic [35:0] act,
                         input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Runs one tile from the start pulse until the cycle after DONE, checking every cycle.
    task automatic run_tile(input logic [10:0] wb, input logic [10:0] xb, input logic [10:0] pb,
                            input logic [7:0] n, input int mode, input bit poke,
                            output int busy_seen);
        pre_t pre[$];
        bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   stage, idx, pops, writes, dcyc;
        bit   prev_xrd, rd_prev, valid_prev, drain_prev, finished;
        int   exec_first;

        for (int k = 0; k < ROW; k++) pre.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 11'(wb + k)});
        for (int k = 0; k < ROW + COL; k++) pre.push_back('{1'b1, 1'b0, (k < ROW), 1'b0, 11'h0});
        for (int k = 0; k < int'(n); k++) pre.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 11'(xb + k)});
        for (int k = 0; k < int'(n); k++) pre.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 11'h0});
        exec_first = 2 * ROW + COL + int'(n);

        w_base = wb; x_base = xb; p_base = pb; n_act = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        stage = 0; idx = 0; pops = 0; writes = 0; dcyc = 0;
        prev_xrd = 1'b0; rd_prev = 1'b0; valid_prev = 1'b0; drain_prev = 1'b0;
        finished = 1'b0; busy_seen = 0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [35:0] exp_w;
            bit rd_now, wr_now, cur_xrd, cur_drain, exp_busy, exp_done, last, v;
            logic [10:0] pa;
            rd_now = 1'b0; wr_now = 1'b0; cur_xrd = 1'b0; cur_drain = 1'b0;
            exp_busy = 1'b1; exp_done = 1'b0; last = 1'b0; pa = 11'h0;
            if (stage == 0) begin
                cur_xrd = pre[idx].xrd;
                exp_w = word(pre[idx].load, pre[idx].ex, prev_xrd, pre[idx].l0rd, 1'b0,
                             pre[idx].xrd, pre[idx].ax, 1'b0, 11'h0);
                idx++;
                if (idx == pre.size()) stage = 1;
            end else if (stage == 1) begin
                cur_drain = 1'b1;
                dcyc++;
                rd_now = drain_prev && valid_prev && (pops < int'(n));
                if (rd_now) pops++;
                wr_now = rd_prev;
                pa = 11'(pb + writes);
                if (wr_now) writes++;
                exp_w = word(1'b0, 1'b0, prev_xrd, 1'b0, rd_now, 1'b0, 11'h0, wr_now, pa);
                if (wr_now && writes == int'(n)) stage = 2;
            end else if (stage == 2) begin
                exp_done = 1'b1;
                exp_w = word(1'b0, 1'b0, prev_xrd, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h0);
                stage = 3;
            end else begin
                exp_busy = 1'b0;
                exp_w = word(1'b0, 1'b0, prev_xrd, 1'b0, 1'b0, 1'b0, 11'h0, 1'b0, 11'h0);
                last = 1'b1;
            end
            check("inst", cyc, inst, exp_w);
            check("busy", cyc, 36'(busy), 36'(exp_busy));
            check("done", cyc, 36'(done), 36'(exp_done));
            if (busy) busy_seen++;
            if (last) begin
                finished = 1'b1;
                break;
            end
            rd_prev = rd_now;
            prev_xrd = cur_xrd;
            if (mode == 2) v = 1'($urandom_range(0, 1));
            else if (cur_drain) v = (mode == 0) ? 1'b1 : pat[(dcyc - 1) % 7];
            else v = 1'b0;
            ofifo_valid = v;
            valid_prev = v;
            drain_prev = cur_drain;
            if (poke && stage == 0 && idx - 1 == exec_first) begin
                start = 1'b1; n_act = 8'd7; w_base = 11'h444; x_base = 11'h555; p_base = 11'h666;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL tile_timeout: got no completion, required completion within 4000 cycles");
        end
    endtask

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1);
    end

    initial begin
        int bs;
        tests = 0; fails = 0;
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b0;
        w_base = '0; x_base = '0; p_base = '0; n_act = '0;

        vecs[0] = '{11'h010, 11'h7FE, 11'h100, 8'd4,   0, 1'b0, 39};
        vecs[1] = '{11'h010, 11'h7FE, 11'h100, 8'd4,   1, 1'b0, 42};
        vecs[2] = '{11'h7FC, 11'h123, 11'h7FE, 8'd3,   0, 1'b1, 36};
        vecs[3] = '{11'h555, 11'h2AA, 11'h3FF, 8'd1,   0, 1'b0, 30};
        vecs[4] = '{11'h000, 11'h000, 11'h000, 8'd255, 0, 1'b0, 792};

        // Reset state
        #12;
        check("reset_inst", 0, inst, 36'h3_0018_0000);
        check("reset_busy", 0, 36'(busy), 36'h0);
        check("reset_done", 0, 36'(done), 36'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // start with n_act=0 is ignored
        n_act = 8'd0; w_base = 11'h010; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("nact0_inst", i, inst, 36'h3_0018_0000);
            check("nact0_busy", i, 36'(busy), 36'h0);
            @(posedge clk); #1;
        end

        foreach (vecs[i]) begin
            run_tile(vecs[i].wb, vecs[i].xb, vecs[i].pb, vecs[i].n, vecs[i].mode, vecs[i].poke, bs);
            check("busy_cycles", i, 36'(bs), 36'(vecs[i].exp_busy));
        end

        // Reset asserted mid-X_RD
        w_base = 11'h010; x_base = 11'h7FE; p_base = 11'h100; n_act = 8'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("xrd_before_reset", 25,
              inst, word(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h7FF, 1'b0, 11'h0));
        ofifo_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("async_reset_inst", 0, inst, 36'h3_0018_0000);
        check("async_reset_busy", 0, 36'(busy), 36'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("held_reset_inst", i, inst, 36'h3_0018_0000);
        end
        ofifo_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("post_reset_idle", i, inst, 36'h3_0018_0000);
            @(posedge clk); #1;
        end
        run_tile(11'h010, 11'h7FE, 11'h100, 8'd4, 0, 1'b0, bs);
        check("post_reset_busy_cycles", 0, 36'(bs), 36'd39);

        // Randomized tiles with random OFIFO occupancy
        for (int r = 0; r < 6; r++) begin
            run_tile(11'($urandom), 11'($urandom), 11'($urandom),
                     8'($urandom_range(1, 12)), 2, 1'($urandom_range(0, 1)), bs);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
